// File: rtl/mic_frame_writer.sv
// mic_frame_writer: assembles per-channel samples into ping-pong frame banks and writes
// them as a ring of records over Avalon-MM. Define MIC_FRAME_HEADER_EN for a 2-word record header.
module mic_frame_writer #(
    parameter int unsigned NUM_CH      = 64,
    parameter int unsigned RING_FRAMES = 16,
    parameter int unsigned ADDR_W      = 17,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned RI_W = (RING_FRAMES > 1) ? $clog2(RING_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              s_valid,
    input  logic [CH_W-1:0]   s_chan,
    input  logic [15:0]       s_data,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [15:0]       m_writedata,
    input  logic              m_waitrequest_n,
    output logic [15:0]       frame_seq,
    output logic [RI_W-1:0]   ring_idx,
    output logic [15:0]       drop_cnt,
    output logic              overflow,
    output logic              sync_err,
    output logic              irq_frame
);

`ifdef MIC_FRAME_HEADER_EN
    localparam int unsigned HDR = 2;
`else
    localparam int unsigned HDR = 0;
`endif
    localparam int unsigned FW        = NUM_CH + HDR;
    localparam int unsigned WI_W      = $clog2(FW + 1);
    localparam logic [15:0] SYNC_WORD = 16'hA55A;

    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         bank_q [2][NUM_CH];
    logic [1:0]          full_q, full_d;
    logic                fill_q, fill_d;
    logic [CH_W-1:0]     exp_q, exp_d;
    logic                resync_q, resync_d;
    logic                drain_q, drain_d;
    logic [WI_W-1:0]     widx_q, widx_d;
    logic                m_write_q, m_write_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [15:0]         m_writedata_q, m_writedata_d;
    logic [15:0]         seq_q, seq_d;
    logic [RI_W-1:0]     ring_q, ring_d;
    logic [15:0]         drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic                serr_q, serr_d;
    logic                irq_q, irq_d;
    logic                clr_pend_q, clr_pend_d;
    logic                ld_c;
    logic [WI_W-1:0]     ld_idx_c;
    logic                acc_c;
    logic                match_c;
    logic                wr_en_c;

    assign m_write     = m_write_q;
    assign m_addr      = m_addr_q;
    assign m_writedata = m_writedata_q;
    assign frame_seq   = seq_q;
    assign ring_idx    = ring_q;
    assign drop_cnt    = drop_q;
    assign overflow    = ovf_q;
    assign sync_err    = serr_q;
    assign irq_frame   = irq_q;

    // Next-state: drain FSM, fill side, then clear override.
    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        fill_d        = fill_q;
        exp_d         = exp_q;
        resync_d      = resync_q;
        drain_d       = drain_q;
        widx_d        = widx_q;
        m_write_d     = m_write_q;
        m_addr_d      = m_addr_q;
        m_writedata_d = m_writedata_q;
        seq_d         = seq_q;
        ring_d        = ring_q;
        drop_d        = drop_q;
        ovf_d         = ovf_q;
        serr_d        = serr_q;
        irq_d         = 1'b0;
        clr_pend_d    = clr_pend_q;
        ld_c          = 1'b0;
        ld_idx_c      = '0;
        wr_en_c       = 1'b0;
        acc_c         = s_valid & enable;
        match_c       = acc_c & (resync_q ? (s_chan == '0) : (s_chan == exp_q));

        case (state_q)
            S_IDLE: begin
                if (|full_q) begin
                    drain_d = full_q[0] ? 1'b0 : 1'b1;
                    ld_c    = 1'b1;
                end
            end
            S_HDR0, S_HDR1, S_DATA: begin
                if (m_write_q && m_waitrequest_n) begin
                    if (32'(widx_q) == FW - 1) begin
                        m_write_d = 1'b0;
                        state_d   = S_DONE;
                        seq_d     = seq_q + 16'd1;
                        ring_d    = (32'(ring_q) == RING_FRAMES - 1) ? '0 : ring_q + RI_W'(1);
                        irq_d     = 1'b1;
                    end else begin
                        ld_c     = 1'b1;
                        ld_idx_c = widx_q + WI_W'(1);
                    end
                end
            end
            S_DONE: begin
                full_d[drain_q] = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Present a word; the header words come first when enabled.
        if (ld_c) begin
            widx_d    = ld_idx_c;
            m_write_d = 1'b1;
            m_addr_d  = ADDR_W'((32'(ring_q) * FW + 32'(ld_idx_c)) * 2);
            if (HDR != 0 && ld_idx_c == '0) begin
                state_d       = S_HDR0;
                m_writedata_d = SYNC_WORD;
            end else if (HDR != 0 && ld_idx_c == WI_W'(1)) begin
                state_d       = S_HDR1;
                m_writedata_d = seq_q;
            end else begin
                state_d       = S_DATA;
                m_writedata_d = bank_q[drain_d][CH_W'(32'(ld_idx_c) - HDR)];
            end
        end

        // Fill side; full_d already reflects a same-cycle release.
        if (acc_c && !match_c && !resync_q) begin
            serr_d   = 1'b1;
            resync_d = 1'b1;
            exp_d    = '0;
        end else if (match_c) begin
            wr_en_c  = 1'b1;
            resync_d = 1'b0;
            if (32'(s_chan) == NUM_CH - 1) begin
                exp_d = '0;
                if (!full_d[~fill_q]) begin
                    full_d[fill_q] = 1'b1;
                    fill_d         = ~fill_q;
                end else begin
                    ovf_d = 1'b1;
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end else begin
                exp_d = s_chan + CH_W'(1);
            end
        end

        // A clear never withdraws a stalled request; it waits for the accept.
        if (clear || clr_pend_q) begin
            if (m_write_q && !m_waitrequest_n) begin
                clr_pend_d = 1'b1;
            end else begin
                clr_pend_d = 1'b0;
                full_d     = '0;
                fill_d     = 1'b0;
                exp_d      = '0;
                resync_d   = 1'b0;
                state_d    = S_IDLE;
                widx_d     = '0;
                m_write_d  = 1'b0;
                seq_d      = '0;
                ring_d     = '0;
                drop_d     = '0;
                ovf_d      = 1'b0;
                serr_d     = 1'b0;
                irq_d      = 1'b0;
                wr_en_c    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            full_q        <= '0;
            fill_q        <= 1'b0;
            exp_q         <= '0;
            resync_q      <= 1'b0;
            drain_q       <= 1'b0;
            widx_q        <= '0;
            m_write_q     <= 1'b0;
            m_addr_q      <= '0;
            m_writedata_q <= '0;
            seq_q         <= '0;
            ring_q        <= '0;
            drop_q        <= '0;
            ovf_q         <= 1'b0;
            serr_q        <= 1'b0;
            irq_q         <= 1'b0;
            clr_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            fill_q        <= fill_d;
            exp_q         <= exp_d;
            resync_q      <= resync_d;
            drain_q       <= drain_d;
            widx_q        <= widx_d;
            m_write_q     <= m_write_d;
            m_addr_q      <= m_addr_d;
            m_writedata_q <= m_writedata_d;
            seq_q         <= seq_d;
            ring_q        <= ring_d;
            drop_q        <= drop_d;
            ovf_q         <= ovf_d;
            serr_q        <= serr_d;
            irq_q         <= irq_d;
            clr_pend_q    <= clr_pend_d;
        end
    end

    // Sample storage; occupancy lives in full_q, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            bank_q[fill_q][s_chan] <= s_data;
        end
    end

endmodule

// File: tb/tb_mic_frame_writer.sv
// Bench for mic_frame_writer: table of frame scenarios on a 4-slot ring, plus hand
// sequences for drop, clear under stall, latency and asynchronous reset.
module tb_mic_frame_writer;

`ifdef MIC_FRAME_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int NCH = 64;
    localparam int FW  = NCH + HDR;
    localparam int AW  = 17;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic          s_valid;
    logic [5:0]    s_chan;
    logic [15:0]   s_data;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_writedata;
    logic          m_waitrequest_n = 1'b1;
    logic [15:0]   frame_seq;
    logic [1:0]    ring_idx;
    logic [15:0]   drop_cnt;
    logic          overflow;
    logic          sync_err;
    logic          irq_frame;

    int checks = 0;
    int errors = 0;

    logic [15:0]   mem [512];
    int            wcnt [512];
    int            irq_cnt = 0;
    bit            stall_all = 1'b0;
    bit            hold_arm = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [15:0]   hold_data = '0;
    int            hold_cnt = 0;
    int            hold_bad = 0;

    typedef struct {
        int tag;
        bit serr_pre;
        bit hold;
        int slot;
        int seq_after;
        int ring_after;
        bit serr_after;
    } vec_t;
    vec_t tbl [5];

    mic_frame_writer #(.NUM_CH(64), .RING_FRAMES(4), .ADDR_W(17)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .s_valid(s_valid), .s_chan(s_chan), .s_data(s_data),
        .m_write(m_write), .m_addr(m_addr), .m_writedata(m_writedata),
        .m_waitrequest_n(m_waitrequest_n), .frame_seq(frame_seq), .ring_idx(ring_idx),
        .drop_cnt(drop_cnt), .overflow(overflow), .sync_err(sync_err), .irq_frame(irq_frame)
    );

    always #5 clk = ~clk;

    // Memory slave: global stall, or a 5-cycle hold on one chosen address.
    always @(posedge clk) begin
        #2;
        m_waitrequest_n = !(stall_all || (hold_arm && m_write && m_addr == hold_addr && hold_cnt < 5));
    end

    function automatic logic [15:0] exp_word(input int w, input int tag, input int seq);
        if (HDR != 0 && w == 0) return 16'hA55A;
        if (HDR != 0 && w == 1) return 16'(seq);
        return {8'(w - HDR), 8'(tag)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int ch, input int tag);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_chan  = 6'(ch);
        s_data  = {8'(ch), 8'(tag)};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int tag);
        for (int ch = 0; ch < NCH; ch++) drive(ch, tag);
        idle(9);
    endtask

    task automatic wait_irq(input int target);
        for (int i = 0; i < 400 && irq_cnt < target; i++) @(negedge clk);
        chk("irq_wait", 32'(irq_cnt), 32'(target));
    endtask

    task automatic clr_slot(input int slot);
        for (int w = 0; w < FW; w++) wcnt[slot * FW + w] = 0;
    endtask

    task automatic chk_record(input int slot, input int tag, input int seq);
        int bad;
        int idx;
        bad = -1;
        for (int w = 0; w < FW; w++) begin
            idx = slot * FW + w;
            if (bad < 0 && (mem[idx] !== exp_word(w, tag, seq) || wcnt[idx] != 1)) bad = w;
        end
        checks++;
        if (bad >= 0) begin
            idx = slot * FW + bad;
            errors++;
            $display("FAIL record slot%0d word%0d: data %h count %0d, expected %h count 1",
                     slot, bad, mem[idx], wcnt[idx], exp_word(bad, tag, seq));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_chan  = '0;
        s_data  = '0;

        tbl[0] = '{0, 1'b0, 1'b0, 0, 1, 1, 1'b0};
        tbl[1] = '{1, 1'b0, 1'b1, 1, 2, 2, 1'b0};
        tbl[2] = '{2, 1'b1, 1'b0, 2, 3, 3, 1'b1};
        tbl[3] = '{3, 1'b0, 1'b0, 3, 4, 0, 1'b1};
        tbl[4] = '{4, 1'b0, 1'b0, 0, 5, 1, 1'b1};

        // Write monitor: records accepted words, irq pulses and held-word stability.
        fork
            forever begin
                @(negedge clk);
                if (m_write && m_waitrequest_n && int'(m_addr[AW-1:1]) < 512) begin
                    mem[int'(m_addr[AW-1:1])] = m_writedata;
                    wcnt[int'(m_addr[AW-1:1])]++;
                end
                if (irq_frame) irq_cnt++;
                if (hold_arm && m_write && !m_waitrequest_n && m_addr == hold_addr) begin
                    hold_cnt++;
                    if (m_writedata !== hold_data) hold_bad++;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_m_write", 32'(m_write), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_m_writedata", 32'(m_writedata), 0);
        chk("rst_frame_seq", 32'(frame_seq), 0);
        chk("rst_ring_idx", 32'(ring_idx), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_flags", {29'd0, overflow, sync_err, irq_frame}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            clr_slot(tbl[i].slot);
            if (tbl[i].hold) begin
                hold_addr = AW'((tbl[i].slot * FW + 10) * 2);
                hold_data = exp_word(10, tbl[i].tag, tbl[i].seq_after - 1);
                hold_cnt  = 0;
                hold_bad  = 0;
                hold_arm  = 1'b1;
            end
            if (tbl[i].serr_pre) begin
                drive(0, tbl[i].tag);
                drive(1, tbl[i].tag);
                drive(3, tbl[i].tag);
                idle(3);
            end
            send_frame(tbl[i].tag);
            wait_irq(i + 1);
            @(negedge clk);
            chk_record(tbl[i].slot, tbl[i].tag, tbl[i].seq_after - 1);
            chk("frame_seq", 32'(frame_seq), 32'(tbl[i].seq_after));
            chk("ring_idx", 32'(ring_idx), 32'(tbl[i].ring_after));
            chk("sync_err", 32'(sync_err), 32'(tbl[i].serr_after));
            if (tbl[i].hold) begin
                chk("hold_cycles", 32'(hold_cnt), 5);
                chk("hold_stable", 32'(hold_bad), 0);
                hold_arm = 1'b0;
            end
        end
        chk("irq_total", 32'(irq_cnt), 5);

        // Drain stalled while two more frames arrive: the second is dropped.
        clr_slot(1);
        clr_slot(2);
        stall_all = 1'b1;
        send_frame(5);
        send_frame(6);
        @(negedge clk);
        chk("drop_cnt", 32'(drop_cnt), 1);
        chk("overflow", 32'(overflow), 1);
        chk("stall_seq", 32'(frame_seq), 5);
        stall_all = 1'b0;
        wait_irq(6);
        send_frame(7);
        wait_irq(7);
        @(negedge clk);
        chk_record(1, 5, 5);
        chk_record(2, 7, 6);
        chk("drop_after", 32'(drop_cnt), 1);
        chk("seq_after_drop", 32'(frame_seq), 7);

        // Clear raised while a word is stalled waits for that word's accept.
        clr_slot(3);
        stall_all = 1'b1;
        send_frame(8);
        chk("clr_req_up", 32'(m_write), 1);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("clr_no_withdraw", 32'(m_write), 1);
        chk("clr_pending_seq", 32'(frame_seq), 7);
        stall_all = 1'b0;
        repeat (3) @(negedge clk);
        chk("clr_m_write", 32'(m_write), 0);
        chk("clr_frame_seq", 32'(frame_seq), 0);
        chk("clr_ring_idx", 32'(ring_idx), 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 0);
        chk("clr_ovf_serr", {30'd0, overflow, sync_err}, 0);
        chk("clr_word_once", 32'(wcnt[3 * FW]), 1);
        chk("clr_word_data", 32'(mem[3 * FW]), 32'(exp_word(0, 8, 7)));
        chk("clr_no_more", 32'(wcnt[3 * FW + 1]), 0);
        chk("clr_no_irq", 32'(irq_cnt), 7);

        // Latency: last sample in cycle t, first request visible in t+2.
        clr_slot(0);
        for (int ch = 0; ch < NCH; ch++) drive(ch, 9);
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1", 32'(m_write), 0);
        @(negedge clk);
        chk("lat_t2", 32'(m_write), 1);
        chk("lat_addr", 32'(m_addr), 0);
        chk("lat_data", 32'(m_writedata), 32'(exp_word(0, 9, 0)));
        wait_irq(8);
        @(negedge clk);
        chk_record(0, 9, 0);
        chk("lat_seq", 32'(frame_seq), 1);

        // Asynchronous reset in the middle of a record.
        send_frame(10);
        @(negedge clk);
        chk("pre_rst_write", 32'(m_write), 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_m_write", 32'(m_write), 0);
        chk("arst_m_addr", 32'(m_addr), 0);
        chk("arst_m_writedata", 32'(m_writedata), 0);
        chk("arst_frame_seq", 32'(frame_seq), 0);
        chk("arst_ring_idx", 32'(ring_idx), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_frame_writer.md
# mic_frame_writer

Downstream stage of the microphone-array capture block: takes the 16-bit per-channel sample stream the capture front end produces and assembles it into 64-channel frames. Frames sit in a two-bank ping-pong buffer and are written to on-chip memory through an Avalon-MM master as a ring of frame records. The block also reports frame progress, drops and stream-sync errors to software.

## Interface
Parameters:
- NUM_CH, 64, channels per frame; s_chan width is clog2(NUM_CH).
- RING_FRAMES, 16, frame records in the memory ring; any value ≥1.
- ADDR_W, 17, master byte-address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- enable  in  1  level; 1 = accept samples
- clear  in  1  one-cycle pulse; resets ring, counters, flags
- s_valid  in  1  sample strobe; no backpressure
- s_chan  in  6  channel index of s_data
- s_data  in  16  sample
- m_write  out  1  Avalon write request
- m_addr  out  ADDR_W  byte address, word-aligned (bit 0 = 0)
- m_writedata  out  16  write data
- m_waitrequest_n  in  1  1 = current word accepted this cycle
- frame_seq  out  16  frames fully written since clear
- ring_idx  out  clog2(RING_FRAMES)  next ring slot to write
- drop_cnt  out  16  frames dropped, saturating at 0xFFFF
- overflow  out  1  sticky; at least one frame dropped
- sync_err  out  1  sticky; channel-order violation seen
- irq_frame  out  1  one-cycle pulse per frame written

## Operation
- Frame words: FW = NUM_CH + HDR, where HDR = 2 with MIC_FRAME_HEADER_EN and 0 without.
- Fill side:
  - An accepted sample is s_valid & enable.
  - The expected channel starts at 0. A sample with s_chan == expected is stored in fill_bank[s_chan], and expected increments.
  - A mismatch sets sync_err, discards the partial frame and enters resync: samples are ignored until the next s_chan == 0, which restarts the frame.
  - The sample at NUM_CH-1 completes the frame. If the other bank is empty, the current bank is marked full, fill_bank toggles and expected = 0.
  - Otherwise the frame is dropped: overflow is set, drop_cnt increments, and the same bank is refilled.
  - A drain release and a frame completion in the same cycle count the bank as empty, so there is no drop.
- Drain FSM, states IDLE, HDR0, HDR1, DATA, DONE:
  - IDLE → HDR0 when any bank is full. Without the header macro the transition goes directly to DATA.
  - HDR0 writes 16'hA55A. HDR1 writes frame_seq. DATA writes ch0..ch(NUM_CH-1) of the oldest full bank.
  - Each word holds m_write, m_addr and m_writedata until a cycle with m_waitrequest_n = 1, then advances.
  - DONE: releases the bank, frame_seq += 1 (wraps at 0xFFFF), ring_idx += 1 (wraps RING_FRAMES-1 → 0), pulses irq_frame, → IDLE.
- Address: m_addr = ((ring_idx·FW + word_idx) · 2), truncated to ADDR_W; word_idx counts 0..FW-1.
- enable low:
  - The fill side ignores samples; a partial frame is kept and resumes at the expected channel.
  - The drain side still completes full banks.
- clear:
  - If m_write & ~m_waitrequest_n, clear is held pending until that word is accepted; no request is withdrawn.
  - When clear takes effect: banks empty, expected = 0, FSM → IDLE, and frame_seq, ring_idx, drop_cnt, overflow and sync_err are zeroed.

## Timing
- Reset values: m_write 0, m_addr 0, m_writedata 0, all counters 0, overflow 0, sync_err 0, irq_frame 0, FSM IDLE, banks empty.
- Latency: the last sample of a frame accepted at cycle t with the drain in IDLE gives the first m_write at t+2.
- With zero wait states, throughput is one word per cycle: a frame takes FW cycles plus 2 cycles of IDLE/DONE overhead.
- irq_frame is asserted in the cycle after the last word is accepted. frame_seq and ring_idx update in that same cycle.
- m_writedata is registered and valid in the same cycle as m_write.
- Reset asserted mid-frame forces all outputs to their reset values immediately.

## Configuration
- MIC_FRAME_HEADER_EN defined: each record is NUM_CH+2 words, sync word 16'hA55A then frame_seq, then samples.
- Not defined: each record is NUM_CH words of samples only. HDR0 and HDR1 are unreachable and FW = NUM_CH.

## Test plan
- Header on, zero wait states. Feed 2 frames with s_data = {chan, frame}. Required:
  - Frame 0 at byte 0: A55A, 0000, samples.
  - Frame 1 at byte 132: A55A, 0001, samples.
  - frame_seq = 2 and 2 irq_frame pulses.
- Hold m_waitrequest_n = 0 for 5 cycles on word 10. Required: m_addr and m_writedata stable for those 5 cycles, and no duplicate or missing words in memory.
- Stall the drain for 3 frame periods. Required: drop_cnt = 1, overflow = 1, and the two buffered frames are written intact.
- RING_FRAMES = 4, 5 frames. Required: the 5th frame is written at byte 0, ring_idx = 1, frame_seq = 5.
- Inject s_chan sequence 0,1,3. Required: sync_err = 1, the frame is discarded, and the next complete frame starting at 0 is written normally.
- Assert clear while m_write is asserted and waitrequest is held low. Required: the write completes on accept, then ring_idx = 0, frame_seq = 0, overflow = 0, sync_err = 0.
